sysio_timer: RTL and testbench

// - Timer/PWM peripheral for one free sysio slot (slot 5, base +0x500); same slot bus as uart/spi/gpio.
// - 32-bit up-counter with 16-bit prescaler, auto-reload, compare, one-shot mode, PWM output, level IRQ.
// - Consumes slot decode (waddr/we/raddr/rd/sel). Returns registered read data.

---
 rtl/sysio_timer.sv | 191 +++++++++++++++++++
 tb/tb_sysio_timer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysio_timer.sv
// sysio_timer: slot-5 timer/PWM peripheral for the sysio slot bus.
// 32-bit up-counter with prescaler, auto-reload, compare, one-shot, PWM and level IRQ.
module sysio_timer #(
  parameter int          PSC_W   = 16,
  parameter logic [31:0] ARR_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic        pwm_o,
  output logic        irq_o
);

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;
  localparam logic [7:0] A_PSC  = 8'h08;
  localparam logic [7:0] A_ARR  = 8'h0C;
  localparam logic [7:0] A_CMP  = 8'h10;
  localparam logic [7:0] A_CNT  = 8'h14;

  logic             r_en;
  logic             r_oneshot;
  logic             r_pwm_en;
  logic             r_irq_en;
  logic             r_ovf;
  logic             r_cmpf;
  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] r_psc_cnt;
  logic [31:0]      r_arr;
  logic [31:0]      r_cmp;
  logic [31:0]      r_cnt;
  logic [31:0]      r_data;
  logic             r_pwm;
  logic             r_irq;

  logic [31:0]      w_bmask;
  logic             w_wr_ctrl;
  logic             w_wr_stat;
  logic             w_wr_psc;
  logic             w_wr_arr;
  logic             w_wr_cmp;
  logic             w_wr_cnt;
  logic             w_tick;
  logic             w_at_arr;
  logic             w_ovf_set;
  logic             w_cmpf_set;
  logic             w_ovf_clr;
  logic             w_cmpf_clr;
  logic             w_en_rise;
  logic [PSC_W-1:0] w_psc_new;
  logic [31:0]      w_arr_new;
  logic [31:0]      w_cmp_new;
  logic [31:0]      w_cnt_new;
  logic [31:0]      w_rdata;

  assign w_bmask = {{8{sel_i[3]}}, {8{sel_i[2]}},
                    {8{sel_i[1]}}, {8{sel_i[0]}}};

  assign w_wr_ctrl = we_i && (waddr_i == A_CTRL);
  assign w_wr_stat = we_i && (waddr_i == A_STAT);
  assign w_wr_psc  = we_i && (waddr_i == A_PSC);
  assign w_wr_arr  = we_i && (waddr_i == A_ARR);
  assign w_wr_cmp  = we_i && (waddr_i == A_CMP);
  assign w_wr_cnt  = we_i && (waddr_i == A_CNT);

  // Byte-lane merge of the write data into each register image.
  assign w_psc_new = (r_psc & ~w_bmask[PSC_W-1:0])
                   | (data_i[PSC_W-1:0] & w_bmask[PSC_W-1:0]);
  assign w_arr_new = (r_arr & ~w_bmask) | (data_i & w_bmask);
  assign w_cmp_new = (r_cmp & ~w_bmask) | (data_i & w_bmask);
  assign w_cnt_new = (r_cnt & ~w_bmask) | (data_i & w_bmask);

  assign w_tick     = r_en && (r_psc_cnt == r_psc);
  assign w_at_arr   = (r_cnt == r_arr);
  assign w_ovf_set  = w_tick && w_at_arr;
  assign w_cmpf_set = w_tick && (r_cnt == r_cmp);

  // A hardware set in the same cycle overrides the software clear.
  assign w_ovf_clr  = w_wr_stat && sel_i[0] && data_i[0];
  assign w_cmpf_clr = w_wr_stat && sel_i[0] && data_i[1];

  assign w_en_rise = w_wr_ctrl && sel_i[0] && data_i[0] && !r_en;

  // CTRL bits; a one-shot overflow drops EN unless software rewrites CTRL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_pwm_en  <= 1'b0;
      r_irq_en  <= 1'b0;
    end else if (w_wr_ctrl && sel_i[0]) begin
      r_en      <= data_i[0];
      r_oneshot <= data_i[1];
      r_pwm_en  <= data_i[2];
      r_irq_en  <= data_i[3];
    end else if (w_ovf_set && r_oneshot) begin
      r_en <= 1'b0;
    end
  end

  // Configuration registers PSC, ARR, CMP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc <= '0;
      r_arr <= ARR_RST;
      r_cmp <= '0;
    end else begin
      if (w_wr_psc) r_psc <= w_psc_new;
      if (w_wr_arr) r_arr <= w_arr_new;
      if (w_wr_cmp) r_cmp <= w_cmp_new;
    end
  end

  // Prescaler: restarts on CNT write or enable, frozen while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc_cnt <= '0;
    end else if (w_wr_cnt || w_en_rise) begin
      r_psc_cnt <= '0;
    end else if (r_en) begin
      r_psc_cnt <= w_tick ? '0 : r_psc_cnt + 1'b1;
    end
  end

  // Main counter; a software write takes priority over the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wr_cnt) begin
      r_cnt <= w_cnt_new;
    end else if (w_tick) begin
      r_cnt <= w_at_arr ? 32'd0 : r_cnt + 32'd1;
    end
  end

  // Sticky status flags with write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_cmpf <= 1'b0;
    end else begin
      r_ovf  <= (r_ovf  && !w_ovf_clr)  || w_ovf_set;
      r_cmpf <= (r_cmpf && !w_cmpf_clr) || w_cmpf_set;
    end
  end

  // PWM and IRQ outputs are registered from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_pwm <= r_pwm_en && r_en && (r_cnt < r_cmp);
      r_irq <= r_irq_en && (r_ovf || r_cmpf);
    end
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    w_rdata = '0;
    case (raddr_i)
      A_CTRL:  w_rdata = {28'd0, r_irq_en, r_pwm_en, r_oneshot, r_en};
      A_STAT:  w_rdata = {30'd0, r_cmpf, r_ovf};
      A_PSC:   w_rdata = {{(32-PSC_W){1'b0}}, r_psc};
      A_ARR:   w_rdata = r_arr;
      A_CMP:   w_rdata = r_cmp;
      A_CNT:   w_rdata = r_cnt;
      default: w_rdata = '0;
    endcase
  end

  // Read data register, held between read pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (rd_i) begin
      r_data <= w_rdata;
    end
  end

  assign data_o = r_data;
  assign pwm_o  = r_pwm;
  assign irq_o  = r_irq;

endmodule

// File: tb/tb_sysio_timer.sv
// tb_sysio_timer: directed vector table, multi-cycle sequences and
// randomized traffic against a behavioural model of the timer.
module tb_sysio_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        we;
  logic [7:0]  raddr;
  logic        rd;
  logic [31:0] data_o;
  logic        pwm_o;
  logic        irq_o;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  sysio_timer dut (
    .clk     (clk),
    .rst     (rst),
    .waddr_i (waddr),
    .data_i  (wdata),
    .sel_i   (sel),
    .we_i    (we),
    .raddr_i (raddr),
    .rd_i    (rd),
    .data_o  (data_o),
    .pwm_o   (pwm_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  bit          m_en, m_os, m_pe, m_ie, m_ovf, m_cmpf, m_pwm, m_irq;
  logic [31:0] m_psc, m_arr, m_cmp, m_cnt, m_pc, m_data;

  task automatic m_reset();
    m_en = 0; m_os = 0; m_pe = 0; m_ie = 0;
    m_ovf = 0; m_cmpf = 0; m_pwm = 0; m_irq = 0;
    m_psc = 0; m_arr = 32'hFFFF_FFFF; m_cmp = 0;
    m_cnt = 0; m_pc = 0; m_data = 0;
  endtask

  function automatic logic [31:0] m_reg(logic [7:0] a);
    case (a)
      8'h00: return {28'd0, m_ie, m_pe, m_os, m_en};
      8'h04: return {30'd0, m_cmpf, m_ovf};
      8'h08: return m_psc;
      8'h0C: return m_arr;
      8'h10: return m_cmp;
      8'h14: return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: evaluate the model on the pre-edge state, then advance.
  task automatic step();
    bit          tick, oset, cset;
    bit          n_en, n_os, n_pe, n_ie, n_ovf, n_cmpf, n_pwm, n_irq;
    logic [31:0] n_psc, n_arr, n_cmp, n_cnt, n_pc, n_data, mask;
    n_en = m_en; n_os = m_os; n_pe = m_pe; n_ie = m_ie;
    n_ovf = m_ovf; n_cmpf = m_cmpf;
    n_psc = m_psc; n_arr = m_arr; n_cmp = m_cmp;
    n_cnt = m_cnt; n_pc = m_pc; n_data = m_data;
    tick = m_en && (m_pc == m_psc);
    oset = tick && (m_cnt == m_arr);
    cset = tick && (m_cnt == m_cmp);
    if (tick) begin
      n_cnt = oset ? 32'd0 : m_cnt + 32'd1;
      n_pc = 0;
      if (oset && m_os) n_en = 0;
    end else if (m_en) begin
      n_pc = (m_pc + 1) % 65536;
    end
    if (oset) n_ovf = 1;
    if (cset) n_cmpf = 1;
    n_pwm = m_pe && m_en && (m_cnt < m_cmp);
    n_irq = m_ie && (m_ovf || m_cmpf);
    if (rd) n_data = m_reg(raddr);
    if (we) begin
      mask = 0;
      for (int k = 0; k < 4; k++)
        if (sel[k]) mask = mask | (32'hFF << (8 * k));
      case (waddr)
        8'h00: if (sel[0]) begin
          if (wdata[0] && !m_en) n_pc = 0;
          n_en = wdata[0]; n_os = wdata[1];
          n_pe = wdata[2]; n_ie = wdata[3];
        end
        8'h04: if (sel[0]) begin
          if (wdata[0] && !oset) n_ovf = 0;
          if (wdata[1] && !cset) n_cmpf = 0;
        end
        8'h08: n_psc = ((m_psc & ~mask) | (wdata & mask)) & 32'hFFFF;
        8'h0C: n_arr = (m_arr & ~mask) | (wdata & mask);
        8'h10: n_cmp = (m_cmp & ~mask) | (wdata & mask);
        8'h14: begin
          n_cnt = (m_cnt & ~mask) | (wdata & mask);
          n_pc = 0;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    m_en = n_en; m_os = n_os; m_pe = n_pe; m_ie = n_ie;
    m_ovf = n_ovf; m_cmpf = n_cmpf; m_pwm = n_pwm; m_irq = n_irq;
    m_psc = n_psc; m_arr = n_arr; m_cmp = n_cmp;
    m_cnt = n_cnt; m_pc = n_pc; m_data = n_data;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d, logic [3:0] s);
    waddr = a; wdata = d; sel = s; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rdchk(string name, logic [7:0] a, logic [31:0] exp);
    raddr = a; rd = 1'b1;
    step();
    rd = 1'b0;
    chk(name, data_o, exp);
  endtask

  task automatic count_pwm(int n, output int hi);
    hi = 0;
    repeat (n) begin
      step();
      if (pwm_o) hi++;
    end
  endtask

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w;
    logic [31:0] e;
  } vec_t;

  vec_t tv [17];

  initial begin
    int hi;
    logic [7:0] ra;

    tv[0]  = '{8'h00, 32'h0,         4'h0, 1'b0, 32'h0};
    tv[1]  = '{8'h04, 32'h0,         4'h0, 1'b0, 32'h0};
    tv[2]  = '{8'h08, 32'h0,         4'h0, 1'b0, 32'h0};
    tv[3]  = '{8'h0C, 32'h0,         4'h0, 1'b0, 32'hFFFF_FFFF};
    tv[4]  = '{8'h10, 32'h0,         4'h0, 1'b0, 32'h0};
    tv[5]  = '{8'h14, 32'h0,         4'h0, 1'b0, 32'h0};
    tv[6]  = '{8'h18, 32'h0,         4'h0, 1'b0, 32'h0};
    tv[7]  = '{8'h08, 32'h1234_56A5, 4'h1, 1'b1, 32'h0000_00A5};
    tv[8]  = '{8'h08, 32'h0000_7700, 4'h2, 1'b1, 32'h0000_77A5};
    tv[9]  = '{8'h08, 32'hFFFF_FFFF, 4'hC, 1'b1, 32'h0000_77A5};
    tv[10] = '{8'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'hDEAD_BEEF};
    tv[11] = '{8'h10, 32'h0,         4'hF, 1'b1, 32'h0};
    tv[12] = '{8'h00, 32'hFFFF_FFF0, 4'hF, 1'b1, 32'h0};
    tv[13] = '{8'h0C, 32'h0000_0012, 4'h1, 1'b1, 32'hFFFF_FF12};
    tv[14] = '{8'h0C, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'hFFFF_FFFF};
    tv[15] = '{8'h08, 32'h0,         4'hF, 1'b1, 32'h0};
    tv[16] = '{8'h1C, 32'h5555_5555, 4'hF, 1'b1, 32'h0};

    rst = 1'b1; waddr = 0; wdata = 0; sel = 0;
    we = 0; raddr = 0; rd = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset data_o", data_o, 32'h0);
    chk("reset pwm_o", {31'd0, pwm_o}, 32'h0);
    chk("reset irq_o", {31'd0, irq_o}, 32'h0);

    for (int i = 0; i < 17; i++) begin
      if (tv[i].w) wr(tv[i].a, tv[i].d, tv[i].s);
      rdchk($sformatf("vec%0d", i), tv[i].a, tv[i].e);
    end

    // Free-run: PSC=1, ARR=4, CNT advances every second clock.
    wr(8'h08, 32'd1, 4'hF);
    wr(8'h0C, 32'd4, 4'hF);
    wr(8'h00, 32'h1, 4'hF);
    for (int k = 1; k <= 10; k++)
      rdchk($sformatf("freerun cnt%0d", k), 8'h14, 32'((k - 1) / 2));
    rdchk("freerun stat ovf", 8'h04, 32'h3);
    wr(8'h04, 32'h1, 4'hF);
    rdchk("w1c ovf only", 8'h04, 32'h2);
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h04, 32'h3, 4'hF);
    rdchk("disable freeze a", 8'h14, 32'd2);
    idle(3);
    rdchk("disable freeze b", 8'h14, 32'd2);

    // One-shot: PSC=0, ARR=3.
    wr(8'h08, 32'd0, 4'hF);
    wr(8'h0C, 32'd3, 4'hF);
    wr(8'h14, 32'd0, 4'hF);
    wr(8'h00, 32'h3, 4'hF);
    idle(5);
    rdchk("oneshot ctrl", 8'h00, 32'h2);
    rdchk("oneshot stat", 8'h04, 32'h3);
    rdchk("oneshot cnt", 8'h14, 32'h0);
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h04, 32'h3, 4'hF);

    // PWM/IRQ: ARR=9, CMP=3.
    wr(8'h0C, 32'd9, 4'hF);
    wr(8'h10, 32'd3, 4'hF);
    wr(8'h14, 32'd0, 4'hF);
    wr(8'h00, 32'hD, 4'hF);
    count_pwm(20, hi);
    chk("pwm duty 3/10", 32'(hi), 32'd6);
    chk("irq after cmpf", {31'd0, irq_o}, 32'h1);
    idle(9);
    wr(8'h04, 32'h3, 4'hF);
    rdchk("ovf set beats w1c", 8'h04, 32'h1);
    wr(8'h10, 32'd0, 4'hF);
    idle(2);
    count_pwm(10, hi);
    chk("pwm cmp0", 32'(hi), 32'd0);
    wr(8'h10, 32'd20, 4'hF);
    idle(2);
    count_pwm(10, hi);
    chk("pwm cmp>arr", 32'(hi), 32'd10);

    // Asynchronous reset between clock edges.
    rdchk("pre-rst arr", 8'h0C, 32'd9);
    chk("pre-rst pwm", {31'd0, pwm_o}, 32'h1);
    chk("pre-rst irq", {31'd0, irq_o}, 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("async pwm", {31'd0, pwm_o}, 32'h0);
    chk("async irq", {31'd0, irq_o}, 32'h0);
    chk("async data", data_o, 32'h0);
    #1 rst = 1'b0;
    m_reset();
    rdchk("post-rst arr", 8'h0C, 32'hFFFF_FFFF);
    wr(8'h00, 32'h1, 4'hF);
    idle(4);
    rdchk("resume cnt", 8'h14, 32'd4);

    // CNT write on a tick cycle wins.
    wr(8'h14, 32'h100, 4'hF);
    rdchk("cnt write wins", 8'h14, 32'h100);

    // ARR below CNT: wrap through 0xFFFF_FFFF without OVF.
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h0C, 32'd5, 4'hF);
    wr(8'h14, 32'd8, 4'hF);
    wr(8'h10, 32'h1000, 4'hF);
    wr(8'h04, 32'h3, 4'hF);
    wr(8'h14, 32'hFFFF_FFFD, 4'hF);
    wr(8'h00, 32'h1, 4'hF);
    idle(3);
    rdchk("wrap to 0", 8'h14, 32'd0);
    idle(4);
    rdchk("no ovf at wrap", 8'h04, 32'h0);
    rdchk("ovf at arr", 8'h04, 32'h1);

    // Randomized traffic against the model.
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      we = ($urandom_range(0, 2) == 0);
      rd = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 7));
      waddr = ra << 2;
      ra = 8'($urandom_range(0, 7));
      raddr = ra << 2;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (waddr)
        8'h00: wdata = 32'($urandom_range(0, 15));
        8'h04: wdata = 32'($urandom_range(0, 3));
        8'h08: wdata = 32'($urandom_range(0, 3));
        8'h0C: wdata = 32'($urandom_range(0, 15));
        8'h10: wdata = 32'($urandom_range(0, 17));
        8'h14: wdata = ($urandom_range(0, 7) == 0)
                     ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                     : 32'($urandom_range(0, 20));
        default: wdata = $urandom;
      endcase
      step();
      chk("rand data_o", data_o, m_data);
      chk("rand pwm_o", {31'd0, pwm_o}, {31'd0, m_pwm});
      chk("rand irq_o", {31'd0, irq_o}, {31'd0, m_irq});
    end
    we = 1'b0;
    rd = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
